local_bht_controller: RTL and testbench

LOCAL_BHT_CONTROLLER -- requirements
Module: local_bht_controller

---
 rtl/lc3b_types.sv | 9 +
 rtl/local_bht_controller_pkg.sv | 24 ++
 rtl/local_bht_controller_if.sv | 41 ++++
 rtl/local_bht_update_queue.sv | 51 +++++
 rtl/local_bht_controller.sv | 83 ++++++++
 tb/tb_local_bht_controller.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the local branch-history pattern array.
package lc3b_types;

    typedef logic [5:0] lc3b_local_bht_pattern_index;
    typedef logic [1:0] lc3b_bht_counter;

    localparam lc3b_bht_counter BHT_WEAK_NT = 2'b01;

endpackage

// File: rtl/local_bht_controller_pkg.sv
// Update-queue entry layout and the saturating counter rule for the local BHT.
package local_bht_controller_pkg;
    import lc3b_types::*;

    localparam int SLOT_COUNT = 64;

    typedef struct packed {
        lc3b_local_bht_pattern_index index;
        logic [5:0]                  slot;
        logic                        taken;
    } upd_entry_t;

    function automatic lc3b_bht_counter sat_update(input lc3b_bht_counter cnt, input logic taken);
        lc3b_bht_counter res;
        res = cnt;
        if (taken && cnt != 2'b11) begin
            res = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/local_bht_controller_if.sv
// Fetch lookup, branch update and pattern-array port bundle for the local BHT controller.
interface local_bht_controller_if
    import lc3b_types::*;
#(
    parameter int width = 128
) ();
    logic                        lookup_valid;
    lc3b_local_bht_pattern_index lookup_index;
    logic [5:0]                  lookup_slot;
    logic                        lookup_ready;
    logic                        pred_valid;
    logic                        pred_taken;
    logic                        upd_valid;
    lc3b_local_bht_pattern_index upd_index;
    logic [5:0]                  upd_slot;
    logic                        upd_taken;
    logic                        upd_ready;
    logic                        init_done;
    lc3b_local_bht_pattern_index arr_index;
    lc3b_local_bht_pattern_index arr_index_in;
    logic                        arr_write;
    logic [width-1:0]            arr_datain;
    logic [width-1:0]            arr_rdata;
    logic [width-1:0]            arr_data;

    modport master (
        output lookup_valid, lookup_index, lookup_slot,
        output upd_valid, upd_index, upd_slot, upd_taken,
        output arr_rdata, arr_data,
        input  lookup_ready, pred_valid, pred_taken, upd_ready, init_done,
        input  arr_index, arr_index_in, arr_write, arr_datain
    );

    modport slave (
        input  lookup_valid, lookup_index, lookup_slot,
        input  upd_valid, upd_index, upd_slot, upd_taken,
        input  arr_rdata, arr_data,
        output lookup_ready, pred_valid, pred_taken, upd_ready, init_done,
        output arr_index, arr_index_in, arr_write, arr_datain
    );
endinterface

// File: rtl/local_bht_update_queue.sv
// Small FIFO of resolved branch updates waiting for an array read-modify-write slot.
module local_bht_update_queue
    import local_bht_controller_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enq_valid,
    input  upd_entry_t enq_entry,
    output logic       enq_ready,
    input  logic       deq_en,
    output upd_entry_t head,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);

    upd_entry_t       store [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [PW:0]      count_reg;
    logic             push;
    logic             pop;

    // Readiness uses only the registered count, so a full queue never accepts even while draining.
    assign enq_ready = count_reg < (PW+1)'(DEPTH);
    assign empty     = count_reg == '0;
    assign push      = enq_valid & enq_ready;
    assign pop       = deq_en & ~empty;
    assign head      = store[head_reg];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[tail_reg] <= enq_entry;
    end
endmodule

// File: rtl/local_bht_controller.sv
// Local BHT controller: sweeps the pattern array to weakly-not-taken, then serves
// lookups and retires queued updates as saturating read-modify-writes.
module local_bht_controller
    import lc3b_types::*;
    import local_bht_controller_pkg::*;
#(
    parameter int width     = 128,
    parameter int UPD_DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    local_bht_controller_if.slave bus
);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam lc3b_local_bht_pattern_index LAST_ROW = '1;

    logic [0:0]                  state_reg;
    logic [0:0]                  state_next;
    lc3b_local_bht_pattern_index sweep_reg;
    logic                        pred_valid_reg;
    logic                        pred_taken_reg;
    logic                        run;
    logic                        lookup_fire;
    logic                        deq_en;
    logic                        q_empty;
    upd_entry_t                  enq_entry;
    upd_entry_t                  head;
    logic [width-1:0]            rmw_data;

    assign run         = state_reg == RUN;
    assign lookup_fire = bus.lookup_valid & run;
    assign deq_en      = run & ~q_empty;
    assign enq_entry   = '{index: bus.upd_index, slot: bus.upd_slot, taken: bus.upd_taken};

    local_bht_update_queue #(.DEPTH(UPD_DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (bus.upd_valid),
        .enq_entry (enq_entry),
        .enq_ready (bus.upd_ready),
        .deq_en    (deq_en),
        .head      (head),
        .empty     (q_empty)
    );

    // Only the head's slot is rewritten; the array's falling-edge write keeps arr_data current.
    generate
        for (genvar gi = 0; gi < SLOT_COUNT; gi++) begin : gen_cnt
            lc3b_bht_counter cur;
            assign cur = bus.arr_data[2*gi +: 2];
            assign rmw_data[2*gi +: 2] = (head.slot == 6'(gi)) ? sat_update(cur, head.taken) : cur;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        if (!run && sweep_reg == LAST_ROW) state_next = RUN;
    end

    assign bus.arr_index    = bus.lookup_index;
    assign bus.arr_index_in = run ? head.index : sweep_reg;
    assign bus.arr_write    = run ? ~q_empty : 1'b1;
    assign bus.arr_datain   = run ? rmw_data : {(width/2){BHT_WEAK_NT}};
    assign bus.lookup_ready = run;
    assign bus.init_done    = run;
    assign bus.pred_valid   = pred_valid_reg;
    assign bus.pred_taken   = pred_taken_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= INIT;
            sweep_reg      <= '0;
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            if (!run) sweep_reg <= sweep_reg + 1'b1;
            pred_valid_reg <= lookup_fire;
            pred_taken_reg <= lookup_fire & bus.arr_rdata[{bus.lookup_slot, 1'b1}];
        end
    end
endmodule

// File: tb/tb_local_bht_controller.sv
// Directed bench for local_bht_controller with a falling-edge-write pattern array model.
module tb_local_bht_controller;
    import lc3b_types::*;

    localparam logic [127:0] ALL01 = {64{2'b01}};

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [127:0] mem [64];
    logic [1:0]   exp_taken [3];
    logic [1:0]   exp_ntaken [4];

    always #5 clk = ~clk;

    local_bht_controller_if #(.width(128)) bus ();

    local_bht_controller #(.width(128), .UPD_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.arr_write === 1'b1) mem[bus.arr_index_in] <= bus.arr_datain;
    end
    assign bus.arr_rdata = mem[bus.arr_index];
    assign bus.arr_data  = mem[bus.arr_index_in];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] row_with(input logic [5:0] slot, input logic [1:0] val);
        logic [127:0] r;
        r = ALL01;
        r[{slot, 1'b0} +: 2] = val;
        return r;
    endfunction

    task automatic set_upd(input logic v, input logic [5:0] idx, input logic [5:0] slot, input logic tk);
        bus.upd_valid = v;
        bus.upd_index = idx;
        bus.upd_slot  = slot;
        bus.upd_taken = tk;
    endtask

    task automatic set_lookup(input logic v, input logic [5:0] idx, input logic [5:0] slot);
        bus.lookup_valid = v;
        bus.lookup_index = idx;
        bus.lookup_slot  = slot;
    endtask

    initial begin
        exp_taken  = '{2'b10, 2'b11, 2'b11};
        exp_ntaken = '{2'b00, 2'b00, 2'b00, 2'b00};
        reset = 1'b1;
        set_upd(1'b0, 6'd0, 6'd0, 1'b0);
        set_lookup(1'b0, 6'd0, 6'd0);
        tick();
        tick();
        chk("rst_init_done", bus.init_done, 1'b0);
        chk("rst_upd_ready", bus.upd_ready, 1'b1);
        chk("rst_lookup_ready", bus.lookup_ready, 1'b0);
        chk("rst_arr_write", bus.arr_write, 1'b1);
        chk("rst_arr_index_in", bus.arr_index_in, 6'd0);
        chk("rst_pred_valid", bus.pred_valid, 1'b0);
        chk("rst_pred_taken", bus.pred_taken, 1'b0);
        reset = 1'b0;

        // Initialisation sweep
        for (int i = 0; i < 64; i++) begin
            chk("init_row", bus.arr_index_in, 128'(i));
            chk("init_write", bus.arr_write, 1'b1);
            chk("init_data", bus.arr_datain, ALL01);
            chk("init_not_done", bus.init_done, 1'b0);
            tick();
        end
        chk("run_init_done", bus.init_done, 1'b1);
        chk("run_lookup_ready", bus.lookup_ready, 1'b1);
        chk("run_idle_write", bus.arr_write, 1'b0);
        for (int r = 0; r < 64; r++) chk("init_mem_row", mem[r], ALL01);

        set_lookup(1'b1, 6'd5, 6'd3);
        chk("arr_index_comb", bus.arr_index, 6'd5);
        tick();
        set_lookup(1'b0, 6'd0, 6'd0);
        chk("lk5_pred_valid", bus.pred_valid, 1'b1);
        chk("lk5_pred_taken", bus.pred_taken, 1'b0);
        tick();
        chk("lk_idle_pred_valid", bus.pred_valid, 1'b0);

        // Three taken updates, row 7 slot 10
        set_upd(1'b1, 6'd7, 6'd10, 1'b1);
        tick();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) bus.upd_valid = 1'b0;
            chk("tk_write", bus.arr_write, 1'b1);
            chk("tk_index_in", bus.arr_index_in, 6'd7);
            chk("tk_datain", bus.arr_datain, row_with(6'd10, exp_taken[k-1]));
            tick();
        end
        chk("tk_drained", bus.arr_write, 1'b0);
        chk("tk_mem7", mem[7], row_with(6'd10, 2'b11));
        set_lookup(1'b1, 6'd7, 6'd10);
        tick();
        set_lookup(1'b0, 6'd0, 6'd0);
        chk("tk_pred_taken", bus.pred_taken, 1'b1);

        // Four not-taken updates, row 2 slot 0
        set_upd(1'b1, 6'd2, 6'd0, 1'b0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) bus.upd_valid = 1'b0;
            chk("nt_index_in", bus.arr_index_in, 6'd2);
            chk("nt_datain", bus.arr_datain, row_with(6'd0, exp_ntaken[k-1]));
            tick();
        end
        chk("nt_mem2", mem[2], row_with(6'd0, 2'b00));
        chk("nt_slot1", mem[2][3:2], 2'b01);

        // Update and lookup meeting on the row being written
        set_upd(1'b1, 6'd9, 6'd4, 1'b1);
        tick();
        bus.upd_valid = 1'b0;
        set_lookup(1'b1, 6'd9, 6'd4);
        chk("byp_write", bus.arr_write, 1'b1);
        chk("byp_index_in", bus.arr_index_in, 6'd9);
        tick();
        set_lookup(1'b0, 6'd0, 6'd0);
        chk("byp_pred_valid", bus.pred_valid, 1'b1);
        chk("byp_pred_taken", bus.pred_taken, 1'b1);
        chk("byp_mem9", mem[9], row_with(6'd4, 2'b10));

        // Six updates offered during INIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            set_upd(1'b1, 6'(20 + j), 6'(j), 1'b1);
            chk("fill_upd_ready", bus.upd_ready, (j < 4) ? 1'b1 : 1'b0);
            tick();
        end
        bus.upd_valid = 1'b0;
        for (int c = 6; c < 64; c++) tick();
        chk("fill_init_done", bus.init_done, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("fill_write", bus.arr_write, 1'b1);
            chk("fill_index_in", bus.arr_index_in, 128'(20 + k));
            chk("fill_datain", bus.arr_datain, row_with(6'(k), 2'b10));
            chk("fill_ready_run", bus.upd_ready, (k == 0) ? 1'b0 : 1'b1);
            tick();
        end
        chk("fill_drained", bus.arr_write, 1'b0);
        chk("fill_ready_back", bus.upd_ready, 1'b1);

        // Reset mid-sweep with queued updates
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_upd(1'b1, 6'd40, 6'd1, 1'b1);
        tick();
        set_upd(1'b1, 6'd41, 6'd2, 1'b0);
        tick();
        bus.upd_valid = 1'b0;
        for (int c = 2; c < 30; c++) tick();
        chk("mid_row30", bus.arr_index_in, 6'd30);
        reset = 1'b1;
        #1;
        chk("mid_rst_row0", bus.arr_index_in, 6'd0);
        chk("mid_rst_init_done", bus.init_done, 1'b0);
        chk("mid_rst_upd_ready", bus.upd_ready, 1'b1);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (c == 0) chk("mid_sweep_start", bus.arr_index_in, 6'd0);
            if (c == 63) chk("mid_not_done", bus.init_done, 1'b0);
            tick();
        end
        chk("mid_init_done", bus.init_done, 1'b1);
        chk("mid_queue_empty", bus.arr_write, 1'b0);
        chk("mid_mem40", mem[40], ALL01);
        chk("mid_mem41", mem[41], ALL01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
